// File: rtl/pe_ctx_seq.sv
// Context sequencer for one PE: holds CTX_DEPTH 64-bit control words and replays
// words 0..ctx_len for loop_cnt+1 iterations. All outputs are registered.
module pe_ctx_seq #(
  parameter int CTX_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [63:0] cfg_data,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  ctx_len,
  input  logic [7:0]  loop_cnt,
  output logic [8:0]  control_in,
  output logic [8:0]  control_out,
  output logic [5:0]  control_reg_1,
  output logic [5:0]  control_reg_2,
  output logic [5:0]  control_put_in,
  output logic [5:0]  control_put_out,
  output logic [5:0]  control_send,
  output logic [3:0]  control_pe2fu_1,
  output logic [3:0]  control_pe2fu_2,
  output logic        ld,
  output logic        ld_write,
  output logic        write_back,
  output logic        busy,
  output logic        done,
  output logic        cfg_err,
  output logic [3:0]  pc
);

  // state | meaning
  // IDLE  | SAFE outputs, context writable, waiting for start
  // RUN   | one context word driven per cycle
  // DONE  | one-cycle completion pulse, SAFE outputs
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Only bits [58:0] carry fields; bit 56 is ld.
  localparam logic [58:0] SAFE_FIELDS = 59'h100_0000_0000_0000;

  state_t      state_q, state_d;
  logic [58:0] ctx_mem [CTX_DEPTH];
  logic [58:0] word_q, word_d;
  logic [3:0]  pc_q, pc_d, pc_inc;
  logic [3:0]  len_q, len_d;
  logic [7:0]  loop_q, loop_d;
  logic [7:0]  iter_q, iter_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        unused_rsvd;

  assign unused_rsvd = ^cfg_data[63:59];
  assign pc_inc      = pc_q + 4'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < CTX_DEPTH; i++) ctx_mem[i] <= SAFE_FIELDS;
    end else if (cfg_we && state_q == IDLE) begin
      ctx_mem[cfg_addr] <= cfg_data[58:0];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      word_q  <= SAFE_FIELDS;
      pc_q    <= 4'd0;
      len_q   <= 4'd0;
      loop_q  <= 8'd0;
      iter_q  <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      iter_q  <= iter_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    pc_d    = pc_q;
    len_d   = len_q;
    loop_d  = loop_q;
    iter_d  = iter_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = cfg_we && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        // ctx_mem[0] is read before any same-edge write lands, so a
        // simultaneous write to address 0 is seen only from the next wrap.
        if (start) begin
          state_d = RUN;
          word_d  = ctx_mem[0];
          pc_d    = 4'd0;
          len_d   = ctx_len;
          loop_d  = loop_cnt;
          iter_d  = 8'd0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          word_d  = SAFE_FIELDS;
          pc_d    = 4'd0;
          busy_d  = 1'b0;
        end else if (pc_q == len_q) begin
          if (iter_q == loop_q) begin
            state_d = DONE;
            word_d  = SAFE_FIELDS;
            pc_d    = 4'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            pc_d    = 4'd0;
            iter_d  = iter_q + 8'd1;
            word_d  = ctx_mem[0];
          end
        end else begin
          pc_d   = pc_inc;
          word_d = ctx_mem[pc_inc];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        word_d  = SAFE_FIELDS;
        pc_d    = 4'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign control_in      = word_q[8:0];
  assign control_out     = word_q[17:9];
  assign control_reg_1   = word_q[23:18];
  assign control_reg_2   = word_q[29:24];
  assign control_put_in  = word_q[35:30];
  assign control_put_out = word_q[41:36];
  assign control_send    = word_q[47:42];
  assign control_pe2fu_1 = word_q[51:48];
  assign control_pe2fu_2 = word_q[55:52];
  assign ld              = word_q[56];
  assign ld_write        = word_q[57];
  assign write_back      = word_q[58];
  assign busy            = busy_q;
  assign done            = done_q;
  assign cfg_err         = err_q;
  assign pc              = pc_q;

endmodule

// File: tb/tb_pe_ctx_seq.sv
// Randomized bench for pe_ctx_seq against a context-array and cycle-count model.
module tb_pe_ctx_seq;

  localparam logic [63:0] SAFE = 64'h0100_0000_0000_0000;
  localparam logic [63:0] FMASK = 64'h07FF_FFFF_FFFF_FFFF;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [63:0] cfg_data;
  logic        start;
  logic        abort;
  logic [3:0]  ctx_len;
  logic [7:0]  loop_cnt;
  logic [8:0]  control_in, control_out;
  logic [5:0]  control_reg_1, control_reg_2, control_put_in, control_put_out, control_send;
  logic [3:0]  control_pe2fu_1, control_pe2fu_2;
  logic        ld, ld_write, write_back, busy, done, cfg_err;
  logic [3:0]  pc;

  logic [63:0] model [16];
  int n_chk = 0;
  int n_pass = 0;

  pe_ctx_seq dut (
    .CLK(CLK), .RST_N(RST_N), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .abort(abort), .ctx_len(ctx_len), .loop_cnt(loop_cnt),
    .control_in(control_in), .control_out(control_out),
    .control_reg_1(control_reg_1), .control_reg_2(control_reg_2),
    .control_put_in(control_put_in), .control_put_out(control_put_out),
    .control_send(control_send), .control_pe2fu_1(control_pe2fu_1),
    .control_pe2fu_2(control_pe2fu_2), .ld(ld), .ld_write(ld_write),
    .write_back(write_back), .busy(busy), .done(done), .cfg_err(cfg_err), .pc(pc)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] obs_word();
    return {5'b0, write_back, ld_write, ld, control_pe2fu_2, control_pe2fu_1,
            control_send, control_put_out, control_put_in, control_reg_2,
            control_reg_1, control_out, control_in};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    cfg_we = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [63:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    model[a] = d;
    @(negedge CLK);
    cfg_we = 1'b0;
    chk("idle_cfg_err", 64'(cfg_err), 64'd0);
  endtask

  // Expected: (len+1)*(loops+1) busy cycles, pc = k mod (len+1), word = ctx[pc],
  // then a single done cycle unless aborted.
  task automatic run_ctx(input int len, input int loops, input int abort_at,
                         input bit poke, input bit co_write,
                         input logic [3:0] wa, input logic [63:0] wd);
    logic [63:0] first0;
    int total, exp_pc;
    bit err_exp, aborted;
    first0 = model[0];
    if (co_write) begin
      cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd; model[wa] = wd;
    end
    start = 1'b1; ctx_len = 4'(len); loop_cnt = 8'(loops);
    total = (len + 1) * (loops + 1);
    err_exp = 1'b0; aborted = 1'b0;
    for (int k = 0; k < total; k++) begin
      @(negedge CLK);
      clear_inputs();
      ctx_len = 4'($urandom); loop_cnt = 8'($urandom);
      exp_pc = k % (len + 1);
      chk("run_busy", 64'(busy), 64'd1);
      chk("run_pc", 64'(pc), 64'(exp_pc));
      chk("run_word", obs_word(), ((k == 0) ? first0 : model[exp_pc]) & FMASK);
      chk("run_cfg_err", 64'(cfg_err), 64'(err_exp));
      chk("run_done", 64'(done), 64'd0);
      err_exp = 1'b0;
      if (k == abort_at) begin
        abort = 1'b1; aborted = 1'b1;
        break;
      end
      if (poke) begin
        if ($urandom_range(0, 2) == 0) start = 1'b1;
        if (k == 0 || $urandom_range(0, 3) == 0) begin
          cfg_we = 1'b1;
          cfg_addr = (k == 0) ? 4'd1 : 4'($urandom);
          cfg_data = {$urandom, $urandom};
          err_exp = 1'b1;
        end
      end
    end
    @(negedge CLK);
    clear_inputs();
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_word", obs_word(), SAFE);
    chk("end_done", 64'(done), aborted ? 64'd0 : 64'd1);
    chk("end_cfg_err", 64'(cfg_err), 64'(err_exp));
    @(negedge CLK);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_word", obs_word(), SAFE);
    chk("idle_cfg_err", 64'(cfg_err), 64'd0);
  endtask

  initial begin
    int len, loops, total, ab;
    RST_N = 1'b0; cfg_addr = 4'd0; cfg_data = 64'd0; ctx_len = 4'd0; loop_cnt = 8'd0;
    clear_inputs();
    for (int i = 0; i < 16; i++) model[i] = SAFE;
    @(negedge CLK); @(negedge CLK);
    chk("rst_word", obs_word(), SAFE);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_pc", 64'(pc), 64'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_word", obs_word(), SAFE);

    run_ctx(15, 0, -1, 1'b0, 1'b0, 4'd0, 64'd0);

    wr(4'd0, 64'h004 | (64'd1 << 30));
    wr(4'd1, 64'h002 | (64'd2 << 30));
    wr(4'd2, 64'h010 | (64'd3 << 30));
    run_ctx(2, 1, -1, 1'b0, 1'b0, 4'd0, 64'd0);

    wr(4'd0, 64'h07FF_FFFF_FFFF_FFFF);
    run_ctx(0, 0, -1, 1'b0, 1'b0, 4'd0, 64'd0);
    wr(4'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    run_ctx(3, 0, -1, 1'b0, 1'b0, 4'd0, 64'd0);

    run_ctx(3, 1, -1, 1'b1, 1'b0, 4'd0, 64'd0);
    run_ctx(2, 1, 2, 1'b1, 1'b0, 4'd0, 64'd0);
    run_ctx(1, 0, 1, 1'b0, 1'b0, 4'd0, 64'd0);
    run_ctx(1, 1, -1, 1'b0, 1'b1, 4'd0, {$urandom, $urandom});
    run_ctx(2, 0, -1, 1'b0, 1'b1, 4'd2, {$urandom, $urandom});

    for (int r = 0; r < 12; r++) begin
      for (int w = 0; w < 4; w++) wr(4'($urandom), {$urandom, $urandom});
      len = $urandom_range(0, 15);
      loops = $urandom_range(0, 3);
      total = (len + 1) * (loops + 1);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, total - 1) : -1;
      run_ctx(len, loops, ab, 1'b1, $urandom_range(0, 1) == 1,
              4'($urandom), {$urandom, $urandom});
    end

    wr(4'd5, 64'h0000_0000_0000_1234);
    start = 1'b1; ctx_len = 4'd7; loop_cnt = 8'd2;
    @(negedge CLK); start = 1'b0;
    @(negedge CLK); @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) model[i] = SAFE;
    chk("mid_rst_word", obs_word(), SAFE);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_pc", 64'(pc), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("post_mid_rst_busy", 64'(busy), 64'd0);
      chk("post_mid_rst_word", obs_word(), SAFE);
    end
    run_ctx(15, 0, -1, 1'b0, 1'b0, 4'd0, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
